// File: rtl/conv_result_streamer.sv
// Streams convolution results out of memory Z as a valid/ready beat stream,
// absorbing the RAM's 1-cycle read latency with a small credit-controlled FIFO.
module conv_result_streamer #(
    parameter int DATA_WIDTH_MEMZ = 16,
    parameter int ADDR_WIDTH_MEMZ = 6,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [ADDR_WIDTH_MEMZ:0]   sizeZ,
    output logic [ADDR_WIDTH_MEMZ-1:0] memZ_raddr,
    input  logic [DATA_WIDTH_MEMZ-1:0] dataZ_read,
    output logic [DATA_WIDTH_MEMZ-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } state_t;

    state_t                     r_state;
    logic [ADDR_WIDTH_MEMZ:0]   r_issueCnt;
    logic [ADDR_WIDTH_MEMZ:0]   r_sendCnt;
    logic [ADDR_WIDTH_MEMZ-1:0] r_addr;
    logic                       r_inflight;
    logic                       r_busy;
    logic                       r_done;

    logic [DATA_WIDTH_MEMZ-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]              r_wptr;
    logic [PW-1:0]              r_rptr;
    logic [CW-1:0]              r_count;

    logic                       w_push;
    logic                       w_pop;
    logic                       w_issue;
    logic                       w_lastPop;
    logic [CW:0]                w_occupancy;

    assign w_push      = r_inflight;
    assign w_pop       = out_valid && out_ready;
    // Credit counts the word still in flight from the RAM so a full FIFO can never be overrun.
    assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    assign w_issue     = (r_state == READ) && (r_issueCnt != '0)
                         && (w_occupancy < (CW+1)'(FIFO_DEPTH));
    assign w_lastPop   = w_pop && (r_sendCnt == (ADDR_WIDTH_MEMZ+1)'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_issueCnt <= '0;
            r_sendCnt  <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_issueCnt <= sizeZ;
                        r_sendCnt  <= sizeZ;
                        r_addr     <= '0;
                        if (sizeZ == '0) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= READ;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (w_pop) begin
                        r_sendCnt <= r_sendCnt - 1'b1;
                    end
                    // The address is left on the last issued word so it never passes sizeZ-1.
                    if (w_issue) begin
                        r_issueCnt <= r_issueCnt - 1'b1;
                        if (r_issueCnt == (ADDR_WIDTH_MEMZ+1)'(1)) begin
                            r_state <= DRAIN;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop) begin
                        r_sendCnt <= r_sendCnt - 1'b1;
                    end
                    if (w_lastPop) begin
                        r_state <= FINISH;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= dataZ_read;
        end
    end

    assign memZ_raddr = r_addr;
    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? r_mem[r_rptr] : '0;
    assign out_last   = out_valid && (r_sendCnt == (ADDR_WIDTH_MEMZ+1)'(1));
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Table-driven bench for conv_result_streamer with a synchronous-read model of memory Z.
module tb_conv_result_streamer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [6:0]  sizeZ;
    logic [5:0]  memZ_raddr;
    logic [15:0] dataZ_read;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [15:0] zmem [64];
    int          compared   = 0;
    int          mismatched = 0;

    typedef struct {
        logic [6:0]  size;
        logic [15:0] base;
        logic [3:0]  readyPat;
        int          restartK;
        int          expLat;
        int          expMaxAddr;
    } vec_t;

    vec_t vecs [6];

    conv_result_streamer #(
        .DATA_WIDTH_MEMZ(16),
        .ADDR_WIDTH_MEMZ(6),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .sizeZ(sizeZ),
        .memZ_raddr(memZ_raddr),
        .dataZ_read(dataZ_read),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Memory Z read port: data appears one cycle after the address.
    always @(posedge clk) begin
        dataZ_read <= zmem[memZ_raddr];
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_last"}, out_last, 0);
        checkOutput({tag, "_data"}, out_data, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_raddr"}, memZ_raddr, 0);
    endtask

    // One complete run: preload Z[i]=base+i, pulse start, watch the stream until done settles.
    task automatic applyStimulus(input int id, input logic [6:0] size, input logic [15:0] base,
                                 input logic [3:0] pat, input int restartK, input int expLat,
                                 input int expMaxAddr);
        int          k;
        int          beats;
        int          firstK;
        int          lastBeatK;
        int          doneK;
        int          doneCount;
        int          lastErr;
        int          busyErr;
        int          stallErr;
        int          maxAddr;
        int          peak;
        int          occ;
        logic        prevStall;
        logic [15:0] prevData;
        logic        prevLast;
        string       tag;

        tag = $sformatf("v%0d", id);
        for (int i = 0; i < 64; i++) zmem[i] = base + 16'(i);
        @(negedge clk);
        sizeZ = size;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; beats = 0; firstK = -1; lastBeatK = -1; doneK = -1; doneCount = 0;
        lastErr = 0; busyErr = 0; stallErr = 0; maxAddr = 0; peak = 0;
        prevStall = 1'b0; prevData = '0; prevLast = 1'b0;
        while (k < 300 && (doneK < 0 || k < doneK + 3)) begin
            if (k == restartK) begin
                start = 1'b1;
                sizeZ = 7'd3;
            end else begin
                start = 1'b0;
            end
            out_ready = pat[k % 4];
            #1;
            if (int'(memZ_raddr) > maxAddr) maxAddr = int'(memZ_raddr);
            occ = int'(dut.r_count) + int'(dut.r_inflight);
            if (occ > peak) peak = occ;
            if (done) begin
                doneCount++;
                if (doneK < 0) doneK = k;
            end
            if (busy != (doneK < 0)) busyErr++;
            if (prevStall && (!out_valid || out_data != prevData || out_last != prevLast)) stallErr++;
            if (out_valid) begin
                if (firstK < 0) firstK = k;
                if (out_last != (beats == int'(size) - 1)) lastErr++;
                if (out_ready) begin
                    checkOutput($sformatf("%s_beat%0d", tag, beats), out_data, base + 16'(beats));
                    beats++;
                    lastBeatK = k;
                end
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevLast  = out_last;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        checkOutput({tag, "_beatCount"}, beats, int'(size));
        checkOutput({tag, "_firstValidLatency"}, firstK, expLat);
        checkOutput({tag, "_donePulses"}, doneCount, 1);
        checkOutput({tag, "_doneCycle"}, doneK, (size == 0) ? 0 : lastBeatK + 1);
        checkOutput({tag, "_lastMisplaced"}, lastErr, 0);
        checkOutput({tag, "_busyErrors"}, busyErr, 0);
        checkOutput({tag, "_stallUnstable"}, stallErr, 0);
        checkOutput({tag, "_maxAddr"}, maxAddr, expMaxAddr);
        checkOutput({tag, "_occupancyWithinDepth"}, (peak <= 4), 1);
        if (pat == 4'hF && size != 0) begin
            checkOutput({tag, "_backToBack"}, lastBeatK - firstK, int'(size) - 1);
        end
    endtask

    initial begin
        int cnt;
        int guard;

        vecs[0] = '{7'd5,  16'h0001, 4'hF,    -1, 2,  4};
        vecs[1] = '{7'd5,  16'h0001, 4'b1001, -1, 2,  4};
        vecs[2] = '{7'd0,  16'h0000, 4'hF,    -1, -1, 0};
        vecs[3] = '{7'd64, 16'h0000, 4'hF,    -1, 2,  63};
        vecs[4] = '{7'd5,  16'h0001, 4'hF,    3,  2,  4};
        vecs[5] = '{7'd7,  16'h0100, 4'b0010, -1, 2,  6};

        for (int i = 0; i < 64; i++) zmem[i] = 16'(i);
        rstn      = 1'b0;
        start     = 1'b0;
        sizeZ     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(v, vecs[v].size, vecs[v].base, vecs[v].readyPat,
                          vecs[v].restartK, vecs[v].expLat, vecs[v].expMaxAddr);
        end

        // Reset after the second accepted beat of a 5-word run, then a fresh 2-word run.
        for (int i = 0; i < 64; i++) zmem[i] = 16'h0010 + 16'(i);
        @(negedge clk);
        sizeZ     = 7'd5;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        guard = 0;
        while (cnt < 2 && guard < 20) begin
            #1;
            if (out_valid && out_ready) cnt++;
            if (cnt < 2) @(negedge clk);
            guard++;
        end
        checkOutput("midReset_twoBeatsSeen", cnt, 2);
        @(negedge clk);
        checkOutput("midReset_runActive", busy, 1);
        rstn = 1'b0;
        #1;
        checkResetOutputs("midReset");
        @(posedge clk);
        #1;
        checkOutput("midReset_noDone", done, 0);
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(10, 7'd2, 16'h0010, 4'hF, -1, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
